// File: rtl/jt49_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt49_seq_pkg
// Description : Shared definitions for the jt49 upstream bus sequencer:
//               FSM state encoding, AY-3-8910 bus-mode codes ({bdir,bc1})
//               and the phase down-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package jt49_seq_pkg;

    // Width of the phase-length down-counter (HOLD/GAP up to 15).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_GAP1  = 3'd2,
        S_XFER  = 3'd3,
        S_GAP2  = 3'd4
    } state_t;

    // Bus modes, encoded as {bdir, bc1}.
    localparam logic [1:0] INACT = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] LATCH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jt49_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : jt49_bus_seq
// Description : Turns single-beat register read/write requests into
//               AY-3-8910 style BDIR/BC1/DA bus cycles for jt49_bus.
//               Sequence: [LATCH, GAP1,] XFER, GAP2. The LATCH/GAP1 pair is
//               skipped when the address cache (CACHE=1) already holds the
//               requested register index.
// Ports       : clk, rst          - clock, async active-high reset
//               req_valid/ready   - request handshake (accepted in IDLE only)
//               req_we/addr/data  - request direction, register, write data
//               rsp_valid/data    - one-cycle read strobe, held read data
//               busy              - inverse of req_ready
//               bdir, bc1         - bus mode to jt49_bus
//               bus_dout, bus_din - data to / from jt49_bus
// Revision    : 1.0 - initial release
// ============================================================================
module jt49_bus_seq
    import jt49_seq_pkg::*;
#(
    parameter int HOLD   = 2,
    parameter int GAP    = 1,
    parameter int RD_LAT = 2,
    parameter int CACHE  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);

    if (HOLD < 1 || HOLD > 15) begin : g_chk_hold
        $error("jt49_bus_seq: HOLD must be in 1..15");
    end
    if (GAP < 1 || GAP > 15) begin : g_chk_gap
        $error("jt49_bus_seq: GAP must be in 1..15");
    end
    if (RD_LAT < 1 || RD_LAT > HOLD) begin : g_chk_rdlat
        $error("jt49_bus_seq: RD_LAT must be in 1..HOLD");
    end

    localparam logic [CNT_W-1:0] c_HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] c_GAP_LD  = CNT_W'(GAP - 1);
    // Counter value during the RD_LAT-th cycle of the read phase
    // (cycle 1 holds HOLD-1, so cycle k holds HOLD-k).
    localparam logic [CNT_W-1:0] c_RD_CNT  = CNT_W'(HOLD - RD_LAT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [3:0]       r_addr;
    logic [7:0]       r_data;
    logic [1:0]       r_mode;
    logic [7:0]       r_dout;
    logic             r_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic [7:0]       r_cap;
    logic             r_cache_vld;
    logic [3:0]       r_cache_addr;

    logic             w_hit;
    logic             w_last;
    logic             w_rd_sample;
    logic [7:0]       w_rd_val;

    assign w_hit       = (CACHE != 0) && r_cache_vld && (req_addr == r_cache_addr);
    assign w_last      = (r_cnt == '0);
    assign w_rd_sample = (r_cnt == c_RD_CNT);
    // When RD_LAT == HOLD the sample cycle is also the exit cycle, so the
    // response takes bus_din directly instead of the (not yet updated) capture.
    assign w_rd_val    = w_rd_sample ? bus_din : r_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= 4'h0;
            r_data       <= 8'h00;
            r_mode       <= INACT;
            r_dout       <= 8'h00;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_cap        <= 8'h00;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= 4'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_ready <= 1'b0;
                        r_cnt   <= c_HOLD_LD;
                        if (w_hit) begin
                            r_state <= S_XFER;
                            r_mode  <= req_we ? WRITE : READ;
                            if (req_we) begin
                                r_dout <= req_data;
                            end
                        end else begin
                            r_state <= S_LATCH;
                            r_mode  <= LATCH;
                            r_dout  <= {4'h0, req_addr};
                        end
                    end
                end
                S_LATCH: begin
                    if (w_last) begin
                        r_cache_vld  <= 1'b1;
                        r_cache_addr <= r_addr;
                        r_state      <= S_GAP1;
                        r_mode       <= INACT;
                        r_cnt        <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP1: begin
                    if (w_last) begin
                        r_state <= S_XFER;
                        r_mode  <= r_we ? WRITE : READ;
                        r_cnt   <= c_HOLD_LD;
                        if (r_we) begin
                            r_dout <= r_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_XFER: begin
                    if (!r_we && w_rd_sample) begin
                        r_cap <= bus_din;
                    end
                    if (w_last) begin
                        r_state <= S_GAP2;
                        r_mode  <= INACT;
                        r_cnt   <= c_GAP_LD;
                        if (!r_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_rd_val;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP2: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mode  <= INACT;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = ~r_ready;
    assign bdir      = r_mode[1];
    assign bc1       = r_mode[0];
    assign bus_dout  = r_dout;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_jt49_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt49_bus_seq
// Description : Self-checking bench for jt49_bus_seq. Two instances: one with
//               default parameters (cached), one with CACHE=0, HOLD=3, GAP=2.
//               Expected bus traces are derived per request from the phase
//               lengths (latch/gap/transfer/gap) and a simple address-cache
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt49_bus_seq;

    localparam int c_HALF = 5;
    localparam int c_H0 = 2, c_G0 = 1, c_RL0 = 2, c_C0 = 1;
    localparam int c_H1 = 3, c_G1 = 2, c_RL1 = 2, c_C1 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       rv   [2];
    logic       rw   [2];
    logic [3:0] ra   [2];
    logic [7:0] rd   [2];
    logic [7:0] bdin [2];
    logic       rdy  [2];
    logic       rspv [2];
    logic [7:0] rspd [2];
    logic       bsy  [2];
    logic       bdir [2];
    logic       bc1  [2];
    logic [7:0] bdout[2];

    // Reference model state
    bit         m_cvld [2];
    logic [3:0] m_caddr[2];
    logic [7:0] m_dout [2];
    logic [7:0] m_rsp  [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #(c_HALF) clk = ~clk;

    jt49_bus_seq #(.HOLD(c_H0), .GAP(c_G0), .RD_LAT(c_RL0), .CACHE(c_C0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rw[0]),
        .req_addr(ra[0]), .req_data(rd[0]),
        .rsp_valid(rspv[0]), .rsp_data(rspd[0]), .busy(bsy[0]),
        .bdir(bdir[0]), .bc1(bc1[0]), .bus_dout(bdout[0]), .bus_din(bdin[0])
    );

    jt49_bus_seq #(.HOLD(c_H1), .GAP(c_G1), .RD_LAT(c_RL1), .CACHE(c_C1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rw[1]),
        .req_addr(ra[1]), .req_data(rd[1]),
        .rsp_valid(rspv[1]), .rsp_data(rspd[1]), .busy(bsy[1]),
        .bdir(bdir[1]), .bc1(bc1[1]), .bus_dout(bdout[1]), .bus_din(bdin[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cvld[s]  = 1'b0;
            m_caddr[s] = 4'h0;
            m_dout[s]  = 8'h00;
            m_rsp[s]   = 8'h00;
        end
    endtask

    task automatic check_idle(input int s, input string where);
        check($sformatf("%s s%0d ready", where, s), 32'(rdy[s]), 32'd1);
        check($sformatf("%s s%0d busy", where, s), 32'(bsy[s]), 32'd0);
        check($sformatf("%s s%0d mode", where, s), {30'd0, bdir[s], bc1[s]}, 32'd0);
        check($sformatf("%s s%0d dout", where, s), 32'(bdout[s]), 32'(m_dout[s]));
        check($sformatf("%s s%0d rspv", where, s), 32'(rspv[s]), 32'd0);
        check($sformatf("%s s%0d rspd", where, s), 32'(rspd[s]), 32'(m_rsp[s]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rv[0] = 1'b0;
            rv[1] = 1'b0;
            check_idle(0, "idle");
            check_idle(1, "idle");
        end
    endtask

    // One request on instance s. If abort is set, rst is pulsed in the
    // middle of the first write-phase cycle and the request is dropped.
    task automatic do_req(input int s, input bit we, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] rdval, input bit abort);
        int h, g, rl, len, rsp_k, xs, j;
        bit miss;
        logic [7:0] pre_d, x_d, ed;
        logic [1:0] em;
        h  = (s == 0) ? c_H0 : c_H1;
        g  = (s == 0) ? c_G0 : c_G1;
        rl = (s == 0) ? c_RL0 : c_RL1;
        miss  = !(((s == 0) ? c_C0 : c_C1) != 0 && m_cvld[s] && m_caddr[s] == a);
        len   = miss ? 2*h + 2*g : h + g;
        rsp_k = miss ? 2*h + g + 1 : h + 1;
        xs    = miss ? h + g : 0;
        pre_d = miss ? {4'h0, a} : m_dout[s];
        x_d   = we ? d : pre_d;

        @(negedge clk);
        rv[1-s] = 1'b0;
        rv[s] = 1'b1; rw[s] = we; ra[s] = a; rd[s] = d;
        bdin[s] = 8'($urandom);
        check_idle(s, "accept");

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            // Garbage on the request inputs while busy must be ignored.
            rv[s] = 1'($urandom); rw[s] = 1'($urandom);
            ra[s] = 4'($urandom); rd[s] = 8'($urandom);
            j = k - xs;
            if (!we && j >= 1 && j <= h)
                bdin[s] = (j == rl) ? rdval : ((j < rl) ? 8'h00 : ~rdval);
            else
                bdin[s] = 8'($urandom);

            if (miss && k <= h) begin
                em = 2'b11; ed = pre_d;
            end else if (miss && k <= h + g) begin
                em = 2'b00; ed = pre_d;
            end else if (j <= h) begin
                em = we ? 2'b10 : 2'b01; ed = x_d;
            end else begin
                em = 2'b00; ed = x_d;
            end
            if (!we && k == rsp_k) m_rsp[s] = rdval;

            check($sformatf("s%0d k%0d mode", s, k), {30'd0, bdir[s], bc1[s]}, 32'(em));
            check($sformatf("s%0d k%0d dout", s, k), 32'(bdout[s]), 32'(ed));
            check($sformatf("s%0d k%0d ready", s, k), 32'(rdy[s]), 32'd0);
            check($sformatf("s%0d k%0d busy", s, k), 32'(bsy[s]), 32'd1);
            check($sformatf("s%0d k%0d rspv", s, k), 32'(rspv[s]), 32'(!we && k == rsp_k));
            check($sformatf("s%0d k%0d rspd", s, k), 32'(rspd[s]), 32'(m_rsp[s]));

            if (abort && k == xs + 1) begin
                #1 rst = 1'b1;
                #1;
                check("async rst mode", {30'd0, bdir[s], bc1[s]}, 32'd0);
                rv[s] = 1'b0;
                model_reset();
                @(negedge clk);
                check_idle(0, "in rst");
                check_idle(1, "in rst");
                rst = 1'b0;
                return;
            end
        end
        if (miss) begin
            m_cvld[s]  = 1'b1;
            m_caddr[s] = a;
        end
        m_dout[s] = x_d;
    endtask

    initial begin
        #(c_HALF * 2 * 20000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0; rw[s] = 1'b0; ra[s] = 4'h0; rd[s] = 8'h00; bdin[s] = 8'h00;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Directed: write miss, write hit, read miss with late data, read hit.
        do_req(0, 1'b1, 4'h7, 8'h38, 8'h00, 1'b0);
        do_req(0, 1'b1, 4'h7, 8'h3F, 8'h00, 1'b0);
        do_req(0, 1'b0, 4'hE, 8'h00, 8'hA5, 1'b0);
        do_req(0, 1'b0, 4'hE, 8'h00, 8'h5C, 1'b0);
        idle(1);
        do_req(0, 1'b1, 4'hE, 8'h77, 8'h00, 1'b0);
        do_req(0, 1'b0, 4'hE, 8'h00, 8'hC3, 1'b0);

        // Reset during the write phase, then same address must re-latch.
        do_req(0, 1'b1, 4'h3, 8'h99, 8'h00, 1'b1);
        do_req(0, 1'b1, 4'h3, 8'h22, 8'h00, 1'b0);

        // Randomized traffic on the cached instance (small address set for hits).
        for (int i = 0; i < 40; i++) begin
            do_req(0, 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
                   8'($urandom), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        // Uncached instance: same address twice, both take the latch path.
        do_req(1, 1'b1, 4'h6, 8'hAB, 8'h00, 1'b0);
        do_req(1, 1'b1, 4'h6, 8'hCD, 8'h00, 1'b0);
        do_req(1, 1'b0, 4'h6, 8'h00, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_req(1, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            idle(int'($urandom_range(0, 1)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
